// File: rtl/vadd_pkg.sv
// Shared types and default sizing for the round-robin vadd scheduler.
package vadd_pkg;
  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam int LAT   = 1;

  typedef logic [LANES*WIDTH-1:0] vec_t;
  typedef logic                   req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } tag_t;
endpackage

// File: rtl/vadd_tag_pipe.sv
// Tag shift register that follows each issued vector through the adder pipeline.
module vadd_tag_pipe
  import vadd_pkg::*;
#(
  parameter int DEPTH = LAT + 1
) (
  input  logic clock,
  input  logic clear,
  input  tag_t din,
  output tag_t tail,
  output logic any_vld
);
  tag_t [DEPTH-1:0] stg;

  always_ff @(posedge clock) begin
    if (clear) begin
      stg <= '0;
    end else begin
      stg[0] <= din;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign tail = stg[DEPTH-1];

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_vld = any_vld | stg[i].vld;
  end
endmodule

// File: rtl/vadd_rr_sched.sv
// Two-requester round-robin front end for a shared vadd adder; routes results back by id tag.
module vadd_rr_sched #(
  parameter int LANES = vadd_pkg::LANES,
  parameter int WIDTH = vadd_pkg::WIDTH,
  parameter int LAT   = vadd_pkg::LAT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [LANES*WIDTH-1:0] req0_a,
  input  logic [LANES*WIDTH-1:0] req0_b,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [LANES*WIDTH-1:0] req1_a,
  input  logic [LANES*WIDTH-1:0] req1_b,
  output logic                   dut_en,
  output logic [LANES*WIDTH-1:0] dut_a,
  output logic [LANES*WIDTH-1:0] dut_b,
  input  logic [LANES*WIDTH-1:0] dut_y,
  output logic                   rsp0_valid,
  output logic [LANES*WIDTH-1:0] rsp0_y,
  output logic                   rsp1_valid,
  output logic [LANES*WIDTH-1:0] rsp1_y,
  output logic                   idle
);
  import vadd_pkg::*;

  req_id_t prio;
  logic    grant_vld;
  req_id_t grant_id;
  tag_t    tag_in;
  tag_t    tail;
  logic    tags_busy;

  // Preferred requester first, then the other; nothing is granted while in reset.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = prio;
    if (!reset) begin
      if (prio ? req1_valid : req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = prio;
      end else if (prio ? req0_valid : req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~prio;
      end
    end
  end

  assign req0_ready = grant_vld && (grant_id == 1'b0);
  assign req1_ready = grant_vld && (grant_id == 1'b1);

  always_ff @(posedge clock) begin
    if (reset) begin
      prio   <= 1'b0;
      dut_en <= 1'b0;
      dut_a  <= '0;
      dut_b  <= '0;
    end else begin
      dut_en <= 1'b1;
      if (grant_vld) begin
        prio  <= ~grant_id;
        dut_a <= grant_id ? req1_a : req0_a;
        dut_b <= grant_id ? req1_b : req0_b;
      end
    end
  end

  assign tag_in = '{vld: grant_vld, id: grant_id};

  vadd_tag_pipe #(.DEPTH(LAT + 1)) u_tags (
    .clock   (clock),
    .clear   (reset),
    .din     (tag_in),
    .tail    (tail),
    .any_vld (tags_busy)
  );

  // The tail tag names the owner of the current dut_y.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_y     <= '0;
      rsp1_y     <= '0;
    end else begin
      rsp0_valid <= tail.vld && !tail.id;
      rsp1_valid <= tail.vld && tail.id;
      if (tail.vld && !tail.id) rsp0_y <= dut_y;
      if (tail.vld && tail.id)  rsp1_y <= dut_y;
    end
  end

  assign idle = !tags_busy && !rsp0_valid && !rsp1_valid;
endmodule

// File: tb/tb_vadd_rr_sched.sv
// Bench for vadd_rr_sched: directed cycle table plus randomized traffic against a transaction-level model.
module tb_vadd_rr_sched;
  import vadd_pkg::*;
  localparam int VW = LANES * WIDTH;
  typedef logic [VW-1:0] v_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 1'b1, req1_valid = 1'b1;
  v_t   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, dut_en, rsp0_valid, rsp1_valid, idle;
  v_t   dut_a, dut_b, dut_y, rsp0_y, rsp1_y;
  int   nvec = 0, nmis = 0;

  vadd_rr_sched #(.LANES(LANES), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .dut_en(dut_en), .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
    .rsp0_valid(rsp0_valid), .rsp0_y(rsp0_y), .rsp1_valid(rsp1_valid), .rsp1_y(rsp1_y),
    .idle(idle)
  );

  always #5 clock = ~clock;

  function automatic v_t vsum(v_t a, v_t b);
    v_t r = '0;
    for (int i = 0; i < LANES; i++) begin
      int s = (int'(a[i*WIDTH +: WIDTH]) + int'(b[i*WIDTH +: WIDTH])) % (1 << WIDTH);
      r[i*WIDTH +: WIDTH] = s[WIDTH-1:0];
    end
    return r;
  endfunction

  function automatic v_t pk(int l0, int l1, int l2, int l3);
    v_t r = '0;
    r[0*WIDTH +: WIDTH] = l0[WIDTH-1:0];
    r[1*WIDTH +: WIDTH] = l1[WIDTH-1:0];
    r[2*WIDTH +: WIDTH] = l2[WIDTH-1:0];
    r[3*WIDTH +: WIDTH] = l3[WIDTH-1:0];
    return r;
  endfunction

  task automatic chk(string nm, v_t act, v_t exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Adder stand-in: LAT-deep lane-wise sum pipeline, advancing only when enabled.
  v_t apipe [LAT];
  always @(posedge clock)
    if (dut_en) begin
      apipe[0] <= vsum(dut_a, dut_b);
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
  assign dut_y = apipe[LAT-1];

  // Transaction model: expected responses queued with their due edge number.
  typedef struct { int due; logic id; v_t y; } exp_t;
  exp_t q[$];
  int   m_g = -1, m_edge = 0;
  logic m_prio = 1'b0, m_en = 1'b0, m_ex0, m_ex1, m_idle;
  logic m_v [2];
  v_t   m_ga, m_gb, m_la = '0, m_lb = '0;
  v_t   m_ry [2];

  initial begin : model
    m_ry[0] = '0; m_ry[1] = '0;
    forever begin
      @(posedge clock);
      m_edge++;
      if (reset) begin
        q.delete();
        m_prio = 1'b0; m_en = 1'b0; m_la = '0; m_lb = '0; m_ry[0] = '0; m_ry[1] = '0;
      end else begin
        m_en = 1'b1;
        if (m_g >= 0) begin
          q.push_back('{due: m_edge + LAT + 1, id: m_g[0], y: vsum(m_ga, m_gb)});
          m_la = m_ga; m_lb = m_gb;
          m_prio = !m_g[0];
        end
      end
      @(negedge clock);
      m_idle = (q.size() == 0);
      m_ex0 = 1'b0; m_ex1 = 1'b0;
      if (q.size() > 0 && q[0].due == m_edge) begin
        if (q[0].id) m_ex1 = 1'b1; else m_ex0 = 1'b1;
        m_ry[q[0].id] = q[0].y;
        q.delete(0);
      end
      chk("m.rsp0_valid", rsp0_valid, m_ex0);
      chk("m.rsp1_valid", rsp1_valid, m_ex1);
      chk("m.rsp0_y", rsp0_y, m_ry[0]);
      chk("m.rsp1_y", rsp1_y, m_ry[1]);
      chk("m.idle", idle, m_idle);
      chk("m.dut_a", dut_a, m_la);
      chk("m.dut_b", dut_b, m_lb);
      chk("m.dut_en", dut_en, m_en);
      m_v[0] = req0_valid; m_v[1] = req1_valid;
      if (reset) m_g = -1;
      else if (m_v[m_prio]) m_g = int'(m_prio);
      else if (m_v[!m_prio]) m_g = int'(!m_prio);
      else m_g = -1;
      chk("m.req0_ready", req0_ready, m_g == 0);
      chk("m.req1_ready", req1_ready, m_g == 1);
      m_ga = (m_g == 1) ? req1_a : req0_a;
      m_gb = (m_g == 1) ? req1_b : req0_b;
    end
  end

  // One row per cycle; with LAT=1 a row's response appears three rows later.
  typedef struct {
    logic rst, v0, v1;
    v_t   a0, b0, a1, b1;
    logic er0, er1, erv0, erv1;
    v_t   ey;
  } row_t;
  row_t tab[$];
  v_t   junk, pb, qb;

  task automatic add(logic rst, logic v0, v_t a0, v_t b0, logic v1, v_t a1, v_t b1,
                     logic er0, logic er1, logic erv0, logic erv1, v_t ey);
    tab.push_back('{rst: rst, v0: v0, v1: v1, a0: a0, b0: b0, a1: a1, b1: b1,
                    er0: er0, er1: er1, erv0: erv0, erv1: erv1, ey: ey});
  endtask

  task automatic idl(logic erv0, logic erv1, v_t ey);
    add(0, 0, junk, junk, 0, junk, junk, 0, 0, erv0, erv1, ey);
  endtask

  function automatic v_t pa(int k); return pk(k+1, k+2, k+3, k+4); endfunction
  function automatic v_t qa(int k); return pk(50+k, 60, 70, 80); endfunction

  logic acc0, acc1;

  initial begin : stim
    junk = pk(9, 9, 9, 9);
    pb   = pk(10, 20, 30, 40);
    qb   = pk(1, 1, 1, 1);
    // contention: grants alternate starting with requester 0
    add(0, 1, pa(0), pb, 1, qa(0), qb, 1, 0, 0, 0, '0);
    add(0, 1, pa(1), pb, 1, qa(0), qb, 0, 1, 0, 0, '0);
    add(0, 1, pa(1), pb, 1, qa(1), qb, 1, 0, 0, 0, '0);
    add(0, 1, pa(2), pb, 1, qa(1), qb, 0, 1, 1, 0, pk(11, 22, 33, 44));
    add(0, 1, pa(2), pb, 1, qa(2), qb, 1, 0, 0, 1, pk(51, 61, 71, 81));
    add(0, 1, pa(3), pb, 1, qa(2), qb, 0, 1, 1, 0, pk(12, 23, 34, 45));
    idl(0, 1, pk(52, 61, 71, 81));
    idl(1, 0, pk(13, 24, 35, 46));
    idl(0, 1, pk(53, 61, 71, 81));
    // single requester back-to-back
    add(0, 1, pk(2, 2, 8, -10), pk(0, 4, 8, 1), 0, junk, junk, 1, 0, 0, 0, '0);
    add(0, 1, pk(1, 1, 1, 1), pk(1, 1, 1, 1), 0, junk, junk, 1, 0, 0, 0, '0);
    idl(0, 0, '0);
    idl(1, 0, pk(2, 6, 16, -9));
    idl(1, 0, pk(2, 2, 2, 2));
    // lane wrap-around
    add(0, 1, pk(127, -128, 255, 100), pk(1, -1, 1, 100), 0, junk, junk, 1, 0, 0, 0, '0);
    idl(0, 0, '0);
    idl(0, 0, '0);
    idl(1, 0, pk('h80, 'h7F, 'h00, 'hC8));
    // priority survives idle cycles
    add(0, 0, junk, junk, 1, qa(5), qb, 0, 1, 0, 0, '0);
    idl(0, 0, '0);
    idl(0, 0, '0);
    add(0, 1, pa(5), pb, 1, qa(6), qb, 1, 0, 0, 1, pk(56, 61, 71, 81));
    add(0, 0, junk, junk, 1, qa(6), qb, 0, 1, 0, 0, '0);
    idl(0, 0, '0);
    idl(1, 0, pk(16, 27, 38, 49));
    idl(0, 1, pk(57, 61, 71, 81));
    // idle gap between two requester-1 vectors
    add(0, 0, junk, junk, 1, qa(7), qb, 0, 1, 0, 0, '0);
    idl(0, 0, '0);
    idl(0, 0, '0);
    idl(0, 1, pk(58, 61, 71, 81));
    add(0, 0, junk, junk, 1, qa(8), qb, 0, 1, 0, 0, '0);
    idl(0, 0, '0);
    idl(0, 0, '0);
    idl(0, 1, pk(59, 61, 71, 81));
    // reset with two vectors in flight, prio left pointing at requester 1
    add(0, 0, junk, junk, 1, qa(9), qb, 0, 1, 0, 0, '0);
    add(0, 1, pa(9), pb, 0, junk, junk, 1, 0, 0, 0, '0);
    add(1, 1, pa(9), pb, 1, qa(9), qb, 0, 0, 0, 0, '0);
    add(1, 1, pa(9), pb, 1, qa(9), qb, 0, 0, 0, 0, '0);
    add(0, 1, pa(10), pb, 1, qa(10), qb, 1, 0, 0, 0, '0);
    add(0, 1, pa(11), pb, 1, qa(10), qb, 0, 1, 0, 0, '0);
    idl(0, 0, '0);
    idl(1, 0, pk(21, 32, 43, 54));
    idl(0, 1, pk(61, 61, 71, 81));
    idl(0, 0, '0);

    // reset state, with both requesters already valid
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst.req0_ready", req0_ready, 1'b0);
    chk("rst.req1_ready", req1_ready, 1'b0);
    chk("rst.dut_en", dut_en, 1'b0);
    chk("rst.dut_a", dut_a, '0);
    chk("rst.rsp0_valid", rsp0_valid, 1'b0);
    chk("rst.rsp1_y", rsp1_y, '0);
    chk("rst.idle", idle, 1'b1);

    foreach (tab[i]) begin
      @(posedge clock); #1;
      reset = tab[i].rst;
      req0_valid = tab[i].v0; req0_a = tab[i].a0; req0_b = tab[i].b0;
      req1_valid = tab[i].v1; req1_a = tab[i].a1; req1_b = tab[i].b1;
      @(negedge clock);
      chk($sformatf("row%0d.req0_ready", i), req0_ready, tab[i].er0);
      chk($sformatf("row%0d.req1_ready", i), req1_ready, tab[i].er1);
      chk($sformatf("row%0d.rsp0_valid", i), rsp0_valid, tab[i].erv0);
      chk($sformatf("row%0d.rsp1_valid", i), rsp1_valid, tab[i].erv1);
      if (tab[i].erv0) chk($sformatf("row%0d.rsp0_y", i), rsp0_y, tab[i].ey);
      if (tab[i].erv1) chk($sformatf("row%0d.rsp1_y", i), rsp1_y, tab[i].ey);
    end

    // random traffic; operands only change once the held vector is accepted
    for (int c = 0; c < 600; c++) begin
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      @(posedge clock); #1;
      reset = ($urandom_range(0, 79) == 0);
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_a = $urandom; req0_b = $urandom;
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_a = $urandom; req1_b = $urandom;
      end
      @(negedge clock);
    end

    @(posedge clock); #1;
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (LAT + 6) @(posedge clock);
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/vadd_rr_sched.md
# vadd_rr_sched

Round-robin scheduler that shares one `vadd` 4-lane vector adder between two requesters. Each requester offers operand vectors over a valid/ready handshake. The scheduler issues at most one vector per cycle into the adder and tracks each issue through the adder pipeline with an id tag. It returns each result as a one-cycle pulse on the response port of the requester that issued it. It sits between the request-side logic and the `vadd` datapath and owns the adder's `en` and operand inputs.

## Interface
- `LANES`, default 4: vector lanes.
- `WIDTH`, default 8: bits per lane.
- `LAT`, default 1: cycles from operands registered at the adder inputs to the matching `y` being valid.
- `clock`  in  1: single clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high.
- `req0_valid`  in  1: requester 0 offers a vector.
- `req0_ready`  out  1: requester 0 is granted this cycle.
- `req0_a`, `req0_b`  in  LANES*WIDTH: requester 0 operands; lane i is bits [i*WIDTH +: WIDTH].
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `dut_en`  out  1: adder enable.
- `dut_a`, `dut_b`  out  LANES*WIDTH: registered operands to the adder.
- `dut_y`  in  LANES*WIDTH: adder result.
- `rsp0_valid`  out  1: result pulse for requester 0.
- `rsp0_y`  out  LANES*WIDTH: result data for requester 0.
- `rsp1_valid`, `rsp1_y`: same as requester 0, for requester 1.
- `idle`  out  1: no vector in flight.

## Operation
- **Arbitration.**
  - The priority pointer `prio` (1 bit) names the preferred requester.
  - Grant rule: grant `prio` if its valid is high; otherwise grant the other requester if its valid is high; otherwise no grant.
  - `reqN_ready` is combinational from both valids and `prio`. At most one ready is high per cycle. A ready is never high without its valid.
  - An accept is `valid && ready` at a clock edge.
  - On every accept, `prio` becomes the non-granted id. It is unchanged on cycles with no accept.
  - With only one requester valid, that requester is granted every cycle (back-to-back).
- **Issue.**
  - On accept, `dut_a` and `dut_b` load the granted operands.
  - With no accept, `dut_a` and `dut_b` hold their previous values.
  - `dut_en` is 1 in every non-reset cycle.
- **Tag pipeline.**
  - A shift register of LAT+1 entries of {vld, id} advances every cycle.
  - Stage 0 is written with {accept, granted id}.
  - When the tail entry has vld=1, `dut_y` belongs to that id.
- **Response.**
  - On the next edge, `rspN_y` is loaded with `dut_y` and `rspN_valid` pulses high for one cycle, for N = tail id.
  - The other requester's valid is 0.
  - `rspN_y` holds its value when not updated.
  - There is no response backpressure; requesters must sink every pulse.
- **Arithmetic.** Lane sums wrap modulo 2^WIDTH (two's complement) inside `vadd`. The scheduler never alters data.
- **`idle`.** High when every tag entry has vld=0 and no response is pending.

## Timing
- **Reset values:** `prio`=0, all tag vld=0, `dut_a`=`dut_b`=0, `dut_en`=0, `rsp0_valid`=`rsp1_valid`=0, `rsp0_y`=`rsp1_y`=0, `idle`=1.
- **Ready during reset:** both readys are 0 while `reset` is high.
- **Latency:** an accept at edge t gives `rspN_valid` high in the cycle after edge t+LAT+1. Minimum request-to-response latency is LAT+2 cycles.
- **Throughput:** one vector per cycle in aggregate. Under contention each requester gets every other cycle.
- **Ordering:** responses return in issue order. Per-requester order is preserved.
- **Reset mid-operation:** all in-flight tags are dropped; no response pulses follow the reset. The first accept after reset goes to requester 0 if both are valid.
- **Handshake stability:** a requester holding valid may change its operands only after its accept.

## Structure
- Package `vadd_pkg`:
  - `LANES`, `WIDTH`, `LAT` defaults.
  - Typedef `vec_t` (LANES*WIDTH bits).
  - Typedef `req_id_t` (1 bit).
  - Struct `tag_t` {vld, id}.
- Sub-module `vadd_tag_pipe`: parameterised depth-LAT+1 shift register of `tag_t` with synchronous clear. Instantiated once.
- The top level contains the arbiter, the operand registers and the response demux.

## Test plan
- **Single requester, back-to-back.**
  - Stimulus: req0 alone sends a={2,2,8,-10}, b={0,4,8,1}, then a={1,1,1,1}, b={1,1,1,1}.
  - Required response: req0_ready high both cycles; rsp0 pulses carry y={2,6,16,-9} then {2,2,2,2}, on consecutive cycles, LAT+2 cycles after each request.
  - rsp1_valid never high.
- **Contention.**
  - Stimulus: both requesters valid for 6 cycles.
  - Required response: grants alternate 0,1,0,1,0,1; responses alternate the same way, with correct per-id data.
- **Wrap-around.**
  - Stimulus: a={127,-128,255,100}, b={1,-1,1,100}.
  - Required response: y={-128,127,0,-56}, i.e. 0x80, 0x7F, 0x00, 0xC8.
- **Idle gaps.**
  - Stimulus: req1 sends one vector, 3 idle cycles, another vector.
  - Required response: exactly two rsp1 pulses; `dut_a` holds during the gap; `idle` rises after the first response and falls on the second accept.
- **Reset mid-flight.**
  - Stimulus: issue 2 vectors, then assert reset 1 cycle later.
  - Required response: no rsp pulses afterwards; all outputs at reset values; after release, both valid → req0 granted first.
- **Priority retention.**
  - Stimulus: req1 granted; then 2 cycles with no valid; then both valid.
  - Required response: req0 granted (prio unchanged across the idle cycles).
